alarm_trigger: RTL and testbench
================================

// Module: alarm_trigger
// PURPOSE
//  Consumer side of the alarm-setting path: compares live clock time (HH:MM digits)
//  against the stored alarm digits and drives the buzzer. Ring/snooze/stop FSM,
//  auto-off after a ring timeout. Sits between the timekeeping counters, the alarm
//  setting block and the buzzer/LED outputs.
// PARAMETERS
//  RING_SECS    60   ticks of ringing before auto-off (>=2)
//  SNOOZE_SECS  300  ticks spent in snooze before re-ringing (>=1)
//  CNT_W        9    width of the shared tick counter; must hold max(RING_SECS,SNOOZE_SECS)-1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  tick       in   1  one-cycle 1 Hz strobe
//  alarm_en   in   1  alarm armed (level)
//  stop       in   1  one-cycle pulse, debounced upstream
//  snooze     in   1  one-cycle pulse, debounced upstream
//  T_H1 in 2, T_H2 in 4, T_M1 in 3, T_M2 in 4   current time digits
//  A_H1 in 2, A_H2 in 4, A_M1 in 3, A_M2 in 4   alarm time digits
//  ringing    out  1  FSM in RING
//  snoozing   out  1  FSM in SNOOZE
//  buzzer     out  1  ringing & beep phase
// BEHAVIOUR
//  - Reset: state=IDLE, ringing=snoozing=buzzer=0, counter=0, match_q=0, beep=0.
//  - match = all four digit pairs equal (combinational); match_q registered every cycle
//    regardless of state/alarm_en; match_rise = match & ~match_q.
//  - Arming while times already equal does NOT ring (no rise). Editing alarm digits onto
//    current time DOES ring (rise occurs).
//  - States IDLE, RING, SNOOZE. Priority per cycle: rst > ~alarm_en > stop > snooze > tick.
//  - Any state, alarm_en=0 -> IDLE next cycle, outputs 0.
//  - IDLE: alarm_en & match_rise -> RING; counter=0, beep=1. ringing=1 one cycle after
//    the rising-match cycle (latency 1).
//  - RING: stop -> IDLE. snooze -> SNOOZE, counter=SNOOZE_SECS-1, beep=0.
//    tick: counter==RING_SECS-1 -> IDLE; else counter+1, beep toggles.
//  - SNOOZE: stop -> IDLE. snooze ignored. tick: counter==0 -> RING, counter=0, beep=1;
//    else counter-1.
//  - match_rise outside IDLE ignored (no restart of ring timeout).
//  - After stop/timeout in the same minute, no re-ring (match stays high, no rise);
//    next ring only on the next rise (next day or alarm edit).
//  - stop and snooze same cycle: stop wins. stop/snooze same cycle as tick: button wins,
//    tick discarded.
//  - buzzer = ringing & beep (1 s on / 1 s off, starts on). Outputs registered.
//  - Counter arithmetic unsigned, CNT_W bits, never wraps (bounded by compares above).
// STRUCTURE
//  - Shared package: state encoding (IDLE=0, RING=1, SNOOZE=2, 2 bits), digit widths
//    (H1=2, H2=4, M1=3, M2=4).
//  - One sub-module natural: time_match (digit compare + match_q edge detect,
//    outputs match_rise). FSM, counter, beep in top.
// TESTING  (bench uses RING_SECS=4, SNOOZE_SECS=3)
//  1 alarm 07:30, en=1, time steps 07:29->07:30 -> ringing=1 next cycle, buzzer=1,0,1,0
//    on successive ticks, ringing=0 after 4th tick.
//  2 ringing, snooze pulse -> snoozing=1, buzzer=0; 3 ticks -> ringing=1, buzzer=1,
//    counter restarted (4 more ticks to auto-off).
//  3 ringing, stop+snooze same cycle -> IDLE; time held 07:30 for 10 ticks -> no re-ring.
//  4 time already 07:30, alarm_en 0->1 -> no ring; then alarm edited 07:31->07:30 -> rings.
//  5 ringing/snoozing, alarm_en=0 -> all outputs 0 next cycle; rst mid-SNOOZE -> IDLE,
//    re-enable with time still matching -> no ring.
//  6 tick and stop same cycle in RING -> IDLE, no beep toggle observed.

Source files
------------

// File: rtl/alarm_trigger_pkg.sv
// rtl/alarm_trigger_pkg.sv - shared state encoding and digit widths for the alarm trigger
package alarm_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam int H1_W = 2;
  localparam int H2_W = 4;
  localparam int M1_W = 3;
  localparam int M2_W = 4;

endpackage

// File: rtl/alarm_trigger_time_match.sv
// rtl/alarm_trigger_time_match.sv - HH:MM digit compare with registered rising-edge detect
module alarm_trigger_time_match
  import alarm_trigger_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [H1_W-1:0] T_H1,
  input  logic [H2_W-1:0] T_H2,
  input  logic [M1_W-1:0] T_M1,
  input  logic [M2_W-1:0] T_M2,
  input  logic [H1_W-1:0] A_H1,
  input  logic [H2_W-1:0] A_H2,
  input  logic [M1_W-1:0] A_M1,
  input  logic [M2_W-1:0] A_M2,
  output logic            match_rise
);

  logic match;
  logic match_q;

  assign match = (T_H1 == A_H1) && (T_H2 == A_H2) && (T_M1 == A_M1) && (T_M2 == A_M2);

  // Tracks match in every state so arming onto an already-equal time sees no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  assign match_rise = match & ~match_q;

endmodule

// File: rtl/alarm_trigger.sv
// rtl/alarm_trigger.sv - alarm ring/snooze/stop FSM with ring timeout and beep cadence
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int CNT_W       = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            alarm_en,
  input  logic            stop,
  input  logic            snooze,
  input  logic [H1_W-1:0] T_H1,
  input  logic [H2_W-1:0] T_H2,
  input  logic [M1_W-1:0] T_M1,
  input  logic [M2_W-1:0] T_M2,
  input  logic [H1_W-1:0] A_H1,
  input  logic [H2_W-1:0] A_H2,
  input  logic [M1_W-1:0] A_M1,
  input  logic [M2_W-1:0] A_M2,
  output logic            ringing,
  output logic            snoozing,
  output logic            buzzer
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beep_q, beep_d;
  logic             match_rise;

  alarm_trigger_time_match u_match (
    .clk        (clk),
    .rst        (rst),
    .T_H1       (T_H1),
    .T_H2       (T_H2),
    .T_M1       (T_M1),
    .T_M2       (T_M2),
    .A_H1       (A_H1),
    .A_H2       (A_H2),
    .A_M1       (A_M1),
    .A_M2       (A_M2),
    .match_rise (match_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beep_q  <= beep_d;
    end
  end

  // Button pulses take precedence over tick; a tick coinciding with one is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beep_d  = beep_q;
    if (!alarm_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      beep_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (match_rise) begin
            state_d = ST_RING;
            cnt_d   = '0;
            beep_d  = 1'b1;
          end
        end
        ST_RING: begin
          if (stop) begin
            state_d = ST_IDLE;
            beep_d  = 1'b0;
          end else if (snooze) begin
            state_d = ST_SNOOZE;
            cnt_d   = SNOOZE_LAST;
            beep_d  = 1'b0;
          end else if (tick) begin
            if (cnt_q == RING_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              beep_d  = 1'b0;
            end else begin
              cnt_d  = cnt_q + CNT_W'(1);
              beep_d = ~beep_q;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == '0) begin
              state_d = ST_RING;
              beep_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          beep_d  = 1'b0;
        end
      endcase
    end
  end

  assign ringing  = (state_q == ST_RING);
  assign snoozing = (state_q == ST_SNOOZE);
  assign buzzer   = ringing & beep_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// tb/tb_alarm_trigger.sv - scoreboard bench for alarm_trigger with RING_SECS=4, SNOOZE_SECS=3
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       alarm_en = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic [1:0] T_H1, A_H1;
  logic [3:0] T_H2, A_H2;
  logic [2:0] T_M1, A_M1;
  logic [3:0] T_M2, A_M2;
  logic       ringing, snoozing, buzzer;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t cur;

  always #5 clk = ~clk;

  alarm_trigger #(
    .RING_SECS   (4),
    .SNOOZE_SECS (3),
    .CNT_W       (9)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .alarm_en (alarm_en),
    .stop     (stop),
    .snooze   (snooze),
    .T_H1     (T_H1),
    .T_H2     (T_H2),
    .T_M1     (T_M1),
    .T_M2     (T_M2),
    .A_H1     (A_H1),
    .A_H2     (A_H2),
    .A_M1     (A_M1),
    .A_M2     (A_M2),
    .ringing  (ringing),
    .snoozing (snoozing),
    .buzzer   (buzzer)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h2,
                          input logic [2:0] m1, input logic [3:0] m2);
    T_H1 = h1; T_H2 = h2; T_M1 = m1; T_M2 = m2;
  endtask

  task automatic set_alarm(input logic [1:0] h1, input logic [3:0] h2,
                           input logic [2:0] m1, input logic [3:0] m2);
    A_H1 = h1; A_H2 = h2; A_M1 = m1; A_M2 = m2;
  endtask

  // Drives one cycle of pulses; exp is {ringing,snoozing,buzzer} after the coming edge.
  task automatic cyc(input string tag, input logic tk, input logic stp, input logic snz,
                     input logic [2:0] exp);
    sb_entry_t e;
    tick = tk; stop = stp; snooze = snz;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check(cur.tag, {29'd0, ringing, snoozing, buzzer}, {29'd0, cur.exp});
    end
  end

  initial begin
    set_time(2'd0, 4'd7, 3'd2, 4'd9);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd0);
    @(negedge clk);

    cyc("reset0", 0, 0, 0, 3'b000);
    cyc("reset1", 1, 0, 0, 3'b000);
    rst = 1'b0;

    // 1: time steps onto the alarm -> ring, beep cadence, auto-off after 4 ticks
    alarm_en = 1'b1;
    cyc("t1_pre", 0, 0, 0, 3'b000);
    set_time(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t1_rise", 0, 0, 0, 3'b101);
    cyc("t1_hold", 0, 0, 0, 3'b101);
    cyc("t1_tk1", 1, 0, 0, 3'b100);
    cyc("t1_tk2", 1, 0, 0, 3'b101);
    cyc("t1_tk3", 1, 0, 0, 3'b100);
    cyc("t1_tk4", 1, 0, 0, 3'b000);
    for (int i = 0; i < 4; i++) cyc("t1_norering", 1, 0, 0, 3'b000);

    // 2: snooze, re-ring after 3 ticks with a fresh 4-tick timeout
    set_time(2'd0, 4'd7, 3'd3, 4'd1);
    cyc("t2_off", 0, 0, 0, 3'b000);
    set_time(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t2_rise", 0, 0, 0, 3'b101);
    cyc("t2_tk1", 1, 0, 0, 3'b100);
    cyc("t2_snz", 0, 0, 1, 3'b010);
    cyc("t2_s1", 1, 0, 0, 3'b010);
    cyc("t2_snzign", 0, 0, 1, 3'b010);
    cyc("t2_s2", 1, 0, 0, 3'b010);
    cyc("t2_s3", 1, 0, 0, 3'b101);
    cyc("t2_r1", 1, 0, 0, 3'b100);
    cyc("t2_r2", 1, 0, 0, 3'b101);
    cyc("t2_r3", 1, 0, 0, 3'b100);
    cyc("t2_r4", 1, 0, 0, 3'b000);

    // 3: stop and snooze together -> stop wins, no re-ring within the minute
    set_time(2'd0, 4'd7, 3'd3, 4'd1);
    cyc("t3_off", 0, 0, 0, 3'b000);
    set_time(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t3_rise", 0, 0, 0, 3'b101);
    cyc("t3_stopsnz", 0, 1, 1, 3'b000);
    for (int i = 0; i < 10; i++) cyc("t3_hold", 1, 0, 0, 3'b000);

    // 4: arming on an already-equal time is silent; editing the alarm onto it rings
    alarm_en = 1'b0;
    cyc("t4_dis", 0, 0, 0, 3'b000);
    alarm_en = 1'b1;
    cyc("t4_arm", 0, 0, 0, 3'b000);
    cyc("t4_armtk", 1, 0, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd1);
    cyc("t4_edit1", 0, 0, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t4_edit2", 0, 0, 0, 3'b101);

    // 5: disable while ringing/snoozing, reset mid-snooze
    alarm_en = 1'b0;
    cyc("t5_disring", 0, 0, 0, 3'b000);
    alarm_en = 1'b1;
    cyc("t5_rearm", 0, 0, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd1);
    cyc("t5_edit1", 0, 0, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t5_rise", 0, 0, 0, 3'b101);
    cyc("t5_snz", 0, 0, 1, 3'b010);
    alarm_en = 1'b0;
    cyc("t5_dissnz", 1, 0, 0, 3'b000);
    alarm_en = 1'b1;
    set_alarm(2'd0, 4'd7, 3'd3, 4'd1);
    cyc("t5_edit3", 0, 0, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t5_rise2", 0, 0, 0, 3'b101);
    cyc("t5_snz2", 0, 0, 1, 3'b010);
    rst = 1'b1;
    alarm_en = 1'b0;
    cyc("t5_rst", 1, 0, 0, 3'b000);
    rst = 1'b0;
    cyc("t5_postrst", 0, 0, 0, 3'b000);
    alarm_en = 1'b1;
    cyc("t5_reen", 0, 0, 0, 3'b000);
    cyc("t5_reentk", 1, 0, 0, 3'b000);

    // 6: tick coinciding with buttons -> button wins, tick discarded
    set_alarm(2'd0, 4'd7, 3'd3, 4'd1);
    cyc("t6_edit1", 0, 0, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t6_rise", 0, 0, 0, 3'b101);
    cyc("t6_tkstop", 1, 1, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd1);
    cyc("t6_edit2", 0, 0, 0, 3'b000);
    set_alarm(2'd0, 4'd7, 3'd3, 4'd0);
    cyc("t6_rise2", 0, 0, 0, 3'b101);
    cyc("t6_tksnz", 1, 0, 1, 3'b010);
    cyc("t6_s1", 1, 0, 0, 3'b010);
    cyc("t6_s2", 1, 0, 0, 3'b010);
    cyc("t6_s3", 1, 0, 0, 3'b101);
    cyc("t6_stop", 0, 1, 0, 3'b000);

    tick = 1'b0; stop = 1'b0; snooze = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
